exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Coprocessor-0 exception and interrupt controller for the 5-stage MIPS pipeline; sits at the M stage.
- Collects the accumulated ExcCode that travels down the pipe from fetch (address-error checks), decode and execute, merges it with masked hardware interrupts, and decides whether to take a trap.
- On a trap it flushes the pipe, redirects fetch to the handler and records EPC/Cause/SR.
- Owns the SR/Cause/EPC/PrID registers, MTC0/MFC0 access and ERET sequencing.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, trap vector driven on redirect_pc.
- PRID_VAL, 32'h2000_0001, constant returned for CP0 register 15.
- SYNC_STAGES, 2, flop depth of the hw_int synchronizer (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_m  in  1  M stage holds a real instruction (0 = bubble).
- pc_m  in  32  PC of the M-stage instruction.
- bd_m  in  1  M-stage instruction is in a branch delay slot.
- exc_code_m  in  5  accumulated ExcCode; 0 = none.
- eret_m  in  1  M-stage instruction is ERET.
- hw_int  in  6  asynchronous device interrupt lines.
- cp0_we  in  1  MTC0 write strobe (M stage).
- cp0_addr  in  5  CP0 register number for read/write.
- cp0_wdata  in  32  MTC0 data.
- cp0_rdata  out  32  MFC0 data, combinational on cp0_addr.
- trap  out  1  exception/interrupt taken this cycle; kills M-stage side effects (DM write, HI/LO).
- flush  out  1  flush F/D/E/M stage registers at the next edge.
- redirect  out  1  PC must load redirect_pc.
- redirect_pc  out  32  HANDLER_ADDR on trap, EPC on ERET.
- epc_out  out  32  current EPC.

Behaviour:
- Reset (reset=0, async): SR=0 (IM=0, EXL=0, IE=0), Cause=0, EPC=0, sync flops=0, state=RUN. cp0_rdata follows registers. trap/flush/redirect=0.
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits 0. Cause is read-only to MTC0.
  - EPC(14): read/write.
  - PrID(15): PRID_VAL.
  - Unmapped addresses read 0; writes to them are ignored.
- IP[15:10] is loaded every cycle from the last synchronizer stage (SYNC_STAGES cycles latency from hw_int).
- int_req = |(IP & IM) & IE & ~EXL & (state==RUN).
- exc_req = valid_m & (exc_code_m != 0) & ~EXL.
- trap = int_req | exc_req (combinational, same cycle).
- Priority: interrupt over exception. On interrupt, ExcCode := 0; otherwise ExcCode := exc_code_m.
- On trap, at the clock edge:
  - EPC := bd_m ? pc_m-4 : pc_m.
  - BD := bd_m.
  - EXL := 1.
  - state := KERNEL.
  - Same cycle: flush=1, redirect=1, redirect_pc=HANDLER_ADDR.
  - If valid_m=0 on an interrupt, EPC still uses pc_m (the bubble carries the next PC).
- MTC0 with trap in the same cycle: the write is dropped.
- ERET (valid_m & eret_m & ~trap): flush=1, redirect=1, redirect_pc=EPC. If cp0_we targets EPC that cycle, cp0_wdata is forwarded. At the edge: EXL := 0, state := RETURN.
- State machine:
  - RUN: trap → KERNEL.
  - KERNEL: interrupts blocked by EXL; ERET → RETURN.
  - RETURN: lasts exactly one cycle with int_req blocked so the returned instruction is fetched; then → RUN.
  - An MTC0 clearing EXL in KERNEL moves state to RUN.
- Exceptions with EXL=1 are ignored (no trap, no register update).
- Reset mid-handler restores all reset values immediately.
- Arithmetic: pc_m-4 is modulo 2^32; no alignment is applied to EPC.

Decomposition:
- Shared package cp0_defs: register numbers (12–15), SR/Cause bit positions, ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12), state encoding RUN/KERNEL/RETURN.
- One sub-module, int_sync: SYNC_STAGES-deep 6-bit flop chain with async active-low clear.

Test Plan:
- Reset then MFC0 of 12/13/14/15 → 0, 0, 0, 32'h2000_0001.
- valid_m=1, pc_m=32'h3008, exc_code_m=4, bd_m=0 → trap=flush=redirect=1, redirect_pc=32'h4180; next cycle EPC=32'h3008, Cause[6:2]=4, SR[1]=1.
- Same as previous with bd_m=1, pc_m=32'h3010 → EPC=32'h300C, Cause[31]=1; a second exc_code_m=12 while EXL=1 → trap=0, Cause unchanged.
- SR=32'h0000_0401 written via MTC0, hw_int[0] raised → trap exactly 2 cycles later, Cause[6:2]=0, Cause[10]=1; a simultaneous exc_code_m=10 is overridden (ExcCode 0).
- In KERNEL, MTC0 EPC=32'h3020 then ERET → redirect_pc=32'h3020, EXL=0; with hw_int still asserted, trap stays 0 in the RETURN cycle and is re-raised the cycle after.
- Assert reset mid-KERNEL → SR/Cause/EPC=0, state RUN, trap=0 without waiting for clk.

Source files
------------

// File: rtl/cp0_defs.sv
// CP0 register map, bit positions, ExcCode values and controller state encoding.
package cp0_defs;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INT_W  = 6;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
    localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
    localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
    localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

    localparam int unsigned SR_IE     = 0;
    localparam int unsigned SR_EXL    = 1;
    localparam int unsigned SR_IM_LSB = 10;
    localparam int unsigned CA_EXC_LSB = 2;
    localparam int unsigned CA_IP_LSB  = 10;
    localparam int unsigned CA_BD      = 31;

    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_KERNEL = 2'd1,
        ST_RETURN = 2'd2
    } state_e;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchronizer for the asynchronous hardware interrupt lines.
module int_sync
    import cp0_defs::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INT_W-1:0] d_i,
    output logic [INT_W-1:0] q_o
);

    logic [SYNC_STAGES-1:0][INT_W-1:0] stage_q;

    // Shift the interrupt lines through the flop chain; async clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: trap decision, redirect, SR/Cause/EPC/PrID.
module exc_ctrl
    import cp0_defs::*;
#(
    parameter logic [XLEN-1:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [XLEN-1:0] PRID_VAL     = 32'h2000_0001,
    parameter int unsigned     SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_m,
    input  logic [XLEN-1:0]   pc_m,
    input  logic              bd_m,
    input  logic [EXC_W-1:0]  exc_code_m,
    input  logic              eret_m,
    input  logic [INT_W-1:0]  hw_int,
    input  logic              cp0_we,
    input  logic [ADDR_W-1:0] cp0_addr,
    input  logic [XLEN-1:0]   cp0_wdata,
    output logic [XLEN-1:0]   cp0_rdata,
    output logic              trap,
    output logic              flush,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [XLEN-1:0]   epc_out
);

    state_e           state_q, state_d;
    logic [INT_W-1:0] im_q, im_d;
    logic             exl_q, exl_d;
    logic             ie_q, ie_d;
    logic             bd_q, bd_d;
    logic [EXC_W-1:0] exc_code_q, exc_code_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [INT_W-1:0] ip;

    logic             int_req, exc_req, eret_go;
    logic [XLEN-1:0]  epc_fwd;

    // The last synchronizer stage is the Cause.IP field.
    int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (hw_int),
        .q_o   (ip)
    );

    // Trap/ERET decision, redirect outputs and next register state.
    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        int_req = (|(ip & im_q)) & ie_q & ~exl_q & (state_q == ST_RUN);
        exc_req = valid_m & (exc_code_m != EXC_INT) & ~exl_q;
        trap    = int_req | exc_req;
        eret_go = valid_m & eret_m & ~trap;
        // An MTC0 to EPC alongside ERET must steer the return address.
        epc_fwd = (cp0_we && (cp0_addr == REG_EPC)) ? cp0_wdata : epc_q;

        flush       = trap | eret_go;
        redirect    = trap | eret_go;
        redirect_pc = trap ? HANDLER_ADDR : epc_fwd;

        if (trap) begin
            epc_d      = bd_m ? (pc_m - 32'd4) : pc_m;
            bd_d       = bd_m;
            exl_d      = 1'b1;
            exc_code_d = int_req ? EXC_INT : exc_code_m;
            state_d    = ST_KERNEL;
        end else begin
            if (cp0_we) begin
                case (cp0_addr)
                    REG_SR: begin
                        im_d  = cp0_wdata[SR_IM_LSB +: INT_W];
                        exl_d = cp0_wdata[SR_EXL];
                        ie_d  = cp0_wdata[SR_IE];
                        if ((state_q == ST_KERNEL) && !cp0_wdata[SR_EXL]) begin
                            state_d = ST_RUN;
                        end
                    end
                    REG_EPC: epc_d = cp0_wdata;
                    default: ;
                endcase
            end
            if (eret_go) begin
                exl_d   = 1'b0;
                state_d = ST_RETURN;
            end else if (state_q == ST_RETURN) begin
                state_d = ST_RUN;
            end
        end
    end

    // CP0 state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // MFC0 read mux; unmapped registers read zero.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            REG_SR:    cp0_rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
            REG_CAUSE: cp0_rdata = {bd_q, 15'b0, ip, 3'b0, exc_code_q, 2'b0};
            REG_EPC:   cp0_rdata = epc_q;
            REG_PRID:  cp0_rdata = PRID_VAL;
            default:   cp0_rdata = '0;
        endcase
    end

    assign epc_out = epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scenario bench for exc_ctrl with an expected-value queue drained against observations.
module tb_exc_ctrl;
    import cp0_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        trap, flush, redirect;
    logic [31:0] redirect_pc, epc_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    string       nm_q[$];

    exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .valid_m     (valid_m),
        .pc_m        (pc_m),
        .bd_m        (bd_m),
        .exc_code_m  (exc_code_m),
        .eret_m      (eret_m),
        .hw_int      (hw_int),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .trap        (trap),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .epc_out     (epc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_m = 1'b0; eret_m = 1'b0; bd_m = 1'b0; exc_code_m = 5'd0;
        cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
    endtask

    task automatic want(input string nm, input logic [31:0] v);
        exp_q.push_back(v);
        nm_q.push_back(nm);
    endtask

    task automatic rd(input logic [4:0] a);
        cp0_addr = a;
        #1;
        obs_q.push_back(cp0_rdata);
    endtask

    task automatic see_ctl();
        #1;
        obs_q.push_back(32'(trap));
        obs_q.push_back(32'(flush));
        obs_q.push_back(32'(redirect));
        obs_q.push_back(redirect_pc);
    endtask

    task automatic test_reset();
        logic [31:0] e, o; string n;
        idle(); hw_int = 6'd0; pc_m = 32'd0; reset = 1'b0;
        #3;
        want("rst_sr", 32'd0);        rd(REG_SR);
        want("rst_cause", 32'd0);     rd(REG_CAUSE);
        want("rst_epc", 32'd0);       rd(REG_EPC);
        want("rst_prid", 32'h2000_0001); rd(REG_PRID);
        want("rst_unmapped", 32'd0);  rd(5'd3);
        want("rst_trap", 32'd0);      obs_q.push_back(32'(trap));
        want("rst_redirect", 32'd0);  obs_q.push_back(32'(redirect));
        #14 reset = 1'b1;
        tick();
        want("rst_epc_out", 32'd0);   obs_q.push_back(epc_out);
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_count: observed %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        end
        exp_q.delete(); obs_q.delete(); nm_q.delete();
    endtask

    task automatic test_exception();
        logic [31:0] e, o; string n;
        valid_m = 1'b1; pc_m = 32'h3008; exc_code_m = EXC_ADEL; bd_m = 1'b0;
        want("exc_trap", 1); want("exc_flush", 1); want("exc_redirect", 1); want("exc_rpc", 32'h4180);
        see_ctl();
        tick(); idle();
        want("exc_epc", 32'h3008);  rd(REG_EPC);
        want("exc_cause", 32'h10);  rd(REG_CAUSE);
        want("exc_sr", 32'h2);      rd(REG_SR);
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL exc_count: observed %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        end
        exp_q.delete(); obs_q.delete(); nm_q.delete();
    endtask

    task automatic test_exception_bd();
        logic [31:0] e, o; string n;
        cp0_we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'd0;
        tick(); idle();
        valid_m = 1'b1; pc_m = 32'h3010; exc_code_m = EXC_ADEL; bd_m = 1'b1;
        want("bd_trap", 1); want("bd_flush", 1); want("bd_redirect", 1); want("bd_rpc", 32'h4180);
        see_ctl();
        tick(); idle();
        want("bd_epc", 32'h300C);       rd(REG_EPC);
        want("bd_cause", 32'h8000_0010); rd(REG_CAUSE);
        valid_m = 1'b1; pc_m = 32'h3050; exc_code_m = EXC_OV;
        #1;
        want("exl_trap", 0);  obs_q.push_back(32'(trap));
        want("exl_flush", 0); obs_q.push_back(32'(flush));
        tick(); idle();
        want("exl_cause", 32'h8000_0010); rd(REG_CAUSE);
        want("exl_epc", 32'h300C);        rd(REG_EPC);
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bd_count: observed %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        end
        exp_q.delete(); obs_q.delete(); nm_q.delete();
    endtask

    task automatic test_interrupt();
        logic [31:0] e, o; string n;
        cp0_we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0401;
        tick(); idle();
        want("int_sr", 32'h401); rd(REG_SR);
        hw_int = 6'b000001;
        #1;
        want("int_lat0", 0); obs_q.push_back(32'(trap));
        tick();
        want("int_lat1", 0); obs_q.push_back(32'(trap));
        tick();
        valid_m = 1'b1; pc_m = 32'h3018; exc_code_m = EXC_RI; bd_m = 1'b0;
        want("int_trap", 1); want("int_flush", 1); want("int_redirect", 1); want("int_rpc", 32'h4180);
        see_ctl();
        tick(); idle();
        want("int_cause", 32'h400); rd(REG_CAUSE);
        want("int_epc", 32'h3018);  rd(REG_EPC);
        want("int_sr_exl", 32'h403); rd(REG_SR);
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL int_count: observed %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        end
        exp_q.delete(); obs_q.delete(); nm_q.delete();
    endtask

    task automatic test_eret();
        logic [31:0] e, o; string n;
        cp0_we = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'h3020;
        #1;
        want("krn_trap", 0); obs_q.push_back(32'(trap));
        tick(); idle();
        want("krn_epc", 32'h3020); rd(REG_EPC);
        valid_m = 1'b1; eret_m = 1'b1;
        want("eret_trap", 0); want("eret_flush", 1); want("eret_redirect", 1); want("eret_rpc", 32'h3020);
        see_ctl();
        tick(); idle();
        want("ret_trap", 0);  obs_q.push_back(32'(trap));
        want("ret_sr", 32'h401); rd(REG_SR);
        tick();
        pc_m = 32'h3024;
        cp0_we = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'hDEAD_BEEF;
        want("rerun_trap", 1); want("rerun_flush", 1); want("rerun_redirect", 1); want("rerun_rpc", 32'h4180);
        see_ctl();
        tick(); idle();
        want("drop_epc", 32'h3024); rd(REG_EPC);
        want("rerun_cause", 32'h400); rd(REG_CAUSE);
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL eret_count: observed %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        end
        exp_q.delete(); obs_q.delete(); nm_q.delete();
    endtask

    task automatic test_eret_forward();
        logic [31:0] e, o; string n;
        hw_int = 6'd0;
        tick(); tick(); tick();
        valid_m = 1'b1; eret_m = 1'b1;
        cp0_we = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'h3040;
        want("fwd_trap", 0); want("fwd_flush", 1); want("fwd_redirect", 1); want("fwd_rpc", 32'h3040);
        see_ctl();
        tick(); idle();
        want("fwd_epc_out", 32'h3040); obs_q.push_back(epc_out);
        want("fwd_sr", 32'h401);       rd(REG_SR);
        tick();
        want("fwd_run_trap", 0); obs_q.push_back(32'(trap));
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fwd_count: observed %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        end
        exp_q.delete(); obs_q.delete(); nm_q.delete();
    endtask

    task automatic test_reset_async();
        logic [31:0] e, o; string n;
        valid_m = 1'b1; pc_m = 32'h3030; exc_code_m = EXC_ADES;
        #1;
        want("ar_trap_pre", 1); obs_q.push_back(32'(trap));
        tick(); idle();
        want("ar_sr_pre", 32'h403);   rd(REG_SR);
        want("ar_cause_pre", 32'h14); rd(REG_CAUSE);
        reset = 1'b0;
        #1;
        want("ar_sr", 32'd0);    rd(REG_SR);
        want("ar_cause", 32'd0); rd(REG_CAUSE);
        want("ar_epc", 32'd0);   rd(REG_EPC);
        want("ar_trap", 0);      obs_q.push_back(32'(trap));
        want("ar_epc_out", 32'd0); obs_q.push_back(epc_out);
        #1 reset = 1'b1;
        tick();
        cp0_we = 1'b1; cp0_addr = REG_SR; cp0_wdata = 32'h0000_0401; hw_int = 6'b000001;
        tick(); idle();
        want("ar_run_lat", 0); obs_q.push_back(32'(trap));
        tick();
        want("ar_run_int", 1); obs_q.push_back(32'(trap));
        hw_int = 6'd0;
        tick();
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ar_count: observed %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s: observed %h expected %h", n, o, e); end
        end
        exp_q.delete(); obs_q.delete(); nm_q.delete();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_exception_bd();
        test_interrupt();
        test_eret();
        test_eret_forward();
        test_reset_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
